// File: rtl/mem_arb_pkg.sv
// Shared types and default widths for the instruction/data memory port arbiter.
package mem_arb_pkg;

  localparam int ADDR_W_DEF = 32;
  localparam int DATA_W_DEF = 32;

  typedef enum logic [1:0] {ST_IDLE, ST_ACCESS, ST_RESP} state_t;
  typedef enum logic {GNT_IF, GNT_D} grant_t;
  typedef enum logic {OP_RD, OP_WR} op_t;

endpackage

// File: rtl/mem_arb_select.sv
// Priority pick between fetch and data requesters with a fetch-starvation counter.
module mem_arb_select
  import mem_arb_pkg::*;
#(
  parameter int STARVE_LIMIT = 4
) (
  input  logic   clk,
  input  logic   rst_n,
  input  logic   arb_en,
  input  logic   if_pend,
  input  logic   d_pend,
  output grant_t gnt
);

  localparam int SC_W = $clog2(STARVE_LIMIT + 1);

  logic [SC_W-1:0] starve_cnt;
  logic [SC_W-1:0] starve_nxt;
  logic            conflict;
  logic            starved;

  always_comb begin
    conflict   = if_pend & d_pend;
    starved    = (starve_cnt == SC_W'(STARVE_LIMIT));
    gnt        = GNT_D;
    if (if_pend && (!d_pend || starved))
      gnt = GNT_IF;
    starve_nxt = starve_cnt;
    if (arb_en && (if_pend || d_pend)) begin
      if (gnt == GNT_IF)
        starve_nxt = '0;
      else if (conflict && !starved)
        starve_nxt = starve_cnt + SC_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n)
      starve_cnt <= '0;
    else
      starve_cnt <= starve_nxt;
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one memory port between instruction fetch and load/store; each access
// runs IDLE (grant) -> ACCESS (MEM_LATENCY cycles) -> RESP (ready pulse) -> IDLE.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W       = ADDR_W_DEF,
  parameter int DATA_W       = DATA_W_DEF,
  parameter int MEM_LATENCY  = 1,
  parameter int STARVE_LIMIT = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_ready,
  output logic [DATA_W-1:0] if_rdata,
  input  logic              d_read,
  input  logic              d_write,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_ready,
  output logic [DATA_W-1:0] d_rdata,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_read,
  output logic              mem_write,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              stall,
  output logic              proto_err
);

  localparam int CNT_W = (MEM_LATENCY > 1) ? $clog2(MEM_LATENCY) : 1;

  state_t            state, state_nxt;
  grant_t            gnt, gnt_q, gnt_q_nxt;
  op_t               op_q, op_q_nxt;
  logic [CNT_W-1:0]  cnt, cnt_nxt;
  logic [ADDR_W-1:0] addr_nxt;
  logic [DATA_W-1:0] wdata_nxt, if_rdata_nxt, d_rdata_nxt;
  logic              rd_nxt, wr_nxt, if_ready_nxt, d_ready_nxt, proto_err_nxt;
  logic              d_pend;

  assign d_pend = d_read | d_write;
  assign stall  = (if_req & ~if_ready) | (d_pend & ~d_ready);

  mem_arb_select #(
    .STARVE_LIMIT (STARVE_LIMIT)
  ) u_sel (
    .clk     (clk),
    .rst_n   (rst_n),
    .arb_en  (state == ST_IDLE),
    .if_pend (if_req),
    .d_pend  (d_pend),
    .gnt     (gnt)
  );

  always_comb begin
    state_nxt     = state;
    cnt_nxt       = cnt;
    gnt_q_nxt     = gnt_q;
    op_q_nxt      = op_q;
    addr_nxt      = mem_addr;
    wdata_nxt     = mem_wdata;
    rd_nxt        = 1'b0;
    wr_nxt        = 1'b0;
    if_ready_nxt  = 1'b0;
    d_ready_nxt   = 1'b0;
    if_rdata_nxt  = if_rdata;
    d_rdata_nxt   = d_rdata;
    proto_err_nxt = 1'b0;
    case (state)
      ST_IDLE: begin
        if (if_req || d_pend) begin
          state_nxt = ST_ACCESS;
          cnt_nxt   = CNT_W'(MEM_LATENCY - 1);
          gnt_q_nxt = gnt;
          if (gnt == GNT_IF) begin
            addr_nxt = if_addr;
            op_q_nxt = OP_RD;
            rd_nxt   = 1'b1;
          end else begin
            // a simultaneous read+write is treated as a store and flagged
            addr_nxt      = d_addr;
            wdata_nxt     = d_wdata;
            op_q_nxt      = d_write ? OP_WR : OP_RD;
            rd_nxt        = ~d_write;
            wr_nxt        = d_write;
            proto_err_nxt = d_read & d_write;
          end
        end
      end
      ST_ACCESS: begin
        if (cnt == '0) begin
          state_nxt = ST_RESP;
          if (gnt_q == GNT_IF) begin
            if_ready_nxt = 1'b1;
            if_rdata_nxt = mem_rdata;
          end else begin
            d_ready_nxt = 1'b1;
            if (op_q == OP_RD)
              d_rdata_nxt = mem_rdata;
          end
        end else begin
          cnt_nxt = cnt - CNT_W'(1);
          rd_nxt  = mem_read;
          wr_nxt  = mem_write;
        end
      end
      ST_RESP:  state_nxt = ST_IDLE;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      cnt       <= '0;
      gnt_q     <= GNT_IF;
      op_q      <= OP_RD;
      mem_addr  <= '0;
      mem_wdata <= '0;
      mem_read  <= 1'b0;
      mem_write <= 1'b0;
      if_ready  <= 1'b0;
      d_ready   <= 1'b0;
      if_rdata  <= '0;
      d_rdata   <= '0;
      proto_err <= 1'b0;
    end else begin
      state     <= state_nxt;
      cnt       <= cnt_nxt;
      gnt_q     <= gnt_q_nxt;
      op_q      <= op_q_nxt;
      mem_addr  <= addr_nxt;
      mem_wdata <= wdata_nxt;
      mem_read  <= rd_nxt;
      mem_write <= wr_nxt;
      if_ready  <= if_ready_nxt;
      d_ready   <= d_ready_nxt;
      if_rdata  <= if_rdata_nxt;
      d_rdata   <= d_rdata_nxt;
      proto_err <= proto_err_nxt;
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench: instance a runs with MEM_LATENCY=1, instance b with MEM_LATENCY=3.
module tb_mem_port_arbiter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  int got;
  logic [5:0] seq;

  logic        rst_n_a, if_req_a, d_read_a, d_write_a;
  logic [31:0] if_addr_a, d_addr_a, d_wdata_a;
  logic        if_ready_a, d_ready_a, mem_read_a, mem_write_a, stall_a, proto_err_a;
  logic [31:0] if_rdata_a, d_rdata_a, mem_addr_a, mem_wdata_a, mem_rdata_a;

  logic        rst_n_b, if_req_b, d_read_b, d_write_b;
  logic [31:0] if_addr_b, d_addr_b, d_wdata_b;
  logic        if_ready_b, d_ready_b, mem_read_b, mem_write_b, stall_b, proto_err_b;
  logic [31:0] if_rdata_b, d_rdata_b, mem_addr_b, mem_wdata_b, mem_rdata_b;

  mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LATENCY(1), .STARVE_LIMIT(4)) u_a (
    .clk(clk), .rst_n(rst_n_a),
    .if_req(if_req_a), .if_addr(if_addr_a), .if_ready(if_ready_a), .if_rdata(if_rdata_a),
    .d_read(d_read_a), .d_write(d_write_a), .d_addr(d_addr_a), .d_wdata(d_wdata_a),
    .d_ready(d_ready_a), .d_rdata(d_rdata_a),
    .mem_addr(mem_addr_a), .mem_wdata(mem_wdata_a), .mem_read(mem_read_a),
    .mem_write(mem_write_a), .mem_rdata(mem_rdata_a),
    .stall(stall_a), .proto_err(proto_err_a)
  );

  mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LATENCY(3), .STARVE_LIMIT(4)) u_b (
    .clk(clk), .rst_n(rst_n_b),
    .if_req(if_req_b), .if_addr(if_addr_b), .if_ready(if_ready_b), .if_rdata(if_rdata_b),
    .d_read(d_read_b), .d_write(d_write_b), .d_addr(d_addr_b), .d_wdata(d_wdata_b),
    .d_ready(d_ready_b), .d_rdata(d_rdata_b),
    .mem_addr(mem_addr_b), .mem_wdata(mem_wdata_b), .mem_read(mem_read_b),
    .mem_write(mem_write_b), .mem_rdata(mem_rdata_b),
    .stall(stall_b), .proto_err(proto_err_b)
  );

  // Memory models: fixed contents unless a word has been written since reset.
  function automatic logic [31:0] rom(input logic [7:0] a);
    case (a)
      8'h10:   rom = 32'h8C010004;
      8'h20:   rom = 32'h11112222;
      8'h80:   rom = 32'h33334444;
      default: rom = {24'hA5A5A5, a};
    endcase
  endfunction

  logic [31:0] ram_a [0:255];
  logic [31:0] ram_b [0:255];
  logic [255:0] vld_a, vld_b;

  always @(posedge clk) begin
    if (!rst_n_a) vld_a <= '0;
    else if (mem_write_a) begin
      ram_a[mem_addr_a[7:0]] <= mem_wdata_a;
      vld_a[mem_addr_a[7:0]] <= 1'b1;
    end
  end

  always @(posedge clk) begin
    if (!rst_n_b) vld_b <= '0;
    else if (mem_write_b) begin
      ram_b[mem_addr_b[7:0]] <= mem_wdata_b;
      vld_b[mem_addr_b[7:0]] <= 1'b1;
    end
  end

  assign mem_rdata_a = vld_a[mem_addr_a[7:0]] ? ram_a[mem_addr_a[7:0]] : rom(mem_addr_a[7:0]);
  assign mem_rdata_b = vld_b[mem_addr_b[7:0]] ? ram_b[mem_addr_b[7:0]] : rom(mem_addr_b[7:0]);

  task automatic step(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic wait_d_b(input string tag, input int exp_n);
    int n;
    n = 0;
    do begin
      step(1);
      n++;
    end while (!d_ready_b && n < 20);
    chk(tag, n, exp_n);
  endtask

  initial begin
    rst_n_a = 1'b0; if_req_a = 1'b1; d_read_a = 1'b1; d_write_a = 1'b1;
    if_addr_a = 32'h10; d_addr_a = 32'h80; d_wdata_a = 32'h5555AAAA;
    rst_n_b = 1'b0; if_req_b = 1'b0; d_read_b = 1'b0; d_write_b = 1'b0;
    if_addr_b = 32'h0; d_addr_b = 32'h0; d_wdata_b = 32'h0;

    // reset held two edges with every request asserted
    step(1);
    chk("rst1_mem_read", mem_read_a, 0);
    chk("rst1_mem_write", mem_write_a, 0);
    step(1);
    chk("rst_mem_read", mem_read_a, 0);
    chk("rst_mem_write", mem_write_a, 0);
    chk("rst_mem_addr", mem_addr_a, 0);
    chk("rst_mem_wdata", mem_wdata_a, 0);
    chk("rst_if_ready", if_ready_a, 0);
    chk("rst_d_ready", d_ready_a, 0);
    chk("rst_if_rdata", if_rdata_a, 0);
    chk("rst_d_rdata", d_rdata_a, 0);
    chk("rst_proto_err", proto_err_a, 0);
    chk("rst_b_if_ready", if_ready_b, 0);
    chk("rst_b_if_rdata", if_rdata_b, 0);
    if_req_a = 1'b0; d_read_a = 1'b0; d_write_a = 1'b0;
    rst_n_a = 1'b1; rst_n_b = 1'b1;
    step(1);
    chk("idle_mem_read", mem_read_a, 0);

    // single fetch, latency 1
    if_addr_a = 32'h10; if_req_a = 1'b1;
    step(1);
    chk("f_mem_read", mem_read_a, 1);
    chk("f_mem_addr", mem_addr_a, 32'h10);
    chk("f_stall", stall_a, 1);
    step(1);
    chk("f_if_ready", if_ready_a, 1);
    chk("f_if_rdata", if_rdata_a, 32'h8C010004);
    chk("f_mem_read_off", mem_read_a, 0);
    chk("f_stall_off", stall_a, 0);
    if_req_a = 1'b0;
    step(1);
    chk("f_if_ready_off", if_ready_a, 0);

    // conflict: data first, then fetch
    if_addr_a = 32'h20; d_addr_a = 32'h80; if_req_a = 1'b1; d_read_a = 1'b1;
    step(1);
    chk("c_mem_addr_d", mem_addr_a, 32'h80);
    chk("c_starve_1", u_a.u_sel.starve_cnt, 1);
    step(1);
    chk("c_d_ready", d_ready_a, 1);
    chk("c_d_rdata", d_rdata_a, 32'h33334444);
    chk("c_if_ready_early", if_ready_a, 0);
    d_read_a = 1'b0;
    step(1);
    chk("c_d_ready_off", d_ready_a, 0);
    chk("c_idle_mem_read", mem_read_a, 0);
    step(1);
    chk("c_mem_addr_if", mem_addr_a, 32'h20);
    chk("c_mem_read_if", mem_read_a, 1);
    chk("c_starve_0", u_a.u_sel.starve_cnt, 0);
    step(1);
    chk("c_if_ready", if_ready_a, 1);
    chk("c_if_rdata", if_rdata_a, 32'h11112222);
    if_req_a = 1'b0;
    step(1);

    // continuous conflict: fetch forced through after STARVE_LIMIT data wins
    if_req_a = 1'b1; d_read_a = 1'b1;
    got = 0; seq = '0;
    for (int c = 0; c < 40 && got < 6; c++) begin
      step(1);
      if (if_ready_a) begin seq[got] = 1'b1; got++; end
      else if (d_ready_a) begin seq[got] = 1'b0; got++; end
    end
    if_req_a = 1'b0; d_read_a = 1'b0;
    chk("starve_count", got, 6);
    chk("starve_order", {26'd0, seq}, {26'd0, 6'b010000});
    step(2);

    // store with latency 3 then read-back
    d_addr_b = 32'h40; d_wdata_b = 32'hDEADBEEF; d_write_b = 1'b1;
    step(1);
    chk("w_mem_write1", mem_write_b, 1);
    chk("w_mem_addr", mem_addr_b, 32'h40);
    chk("w_mem_wdata", mem_wdata_b, 32'hDEADBEEF);
    chk("w_mem_read", mem_read_b, 0);
    chk("w_stall", stall_b, 1);
    step(1);
    chk("w_mem_write2", mem_write_b, 1);
    step(1);
    chk("w_mem_write3", mem_write_b, 1);
    chk("w_d_ready_early", d_ready_b, 0);
    step(1);
    chk("w_mem_write_off", mem_write_b, 0);
    chk("w_d_ready", d_ready_b, 1);
    chk("w_d_rdata_kept", d_rdata_b, 0);
    d_write_b = 1'b0;
    step(1);
    chk("w_d_ready_off", d_ready_b, 0);
    d_read_b = 1'b1;
    wait_d_b("rb_latency", 4);
    chk("rb_d_rdata", d_rdata_b, 32'hDEADBEEF);
    d_read_b = 1'b0;
    step(1);

    // reset during the second ACCESS cycle, then re-issue
    d_addr_b = 32'h80; d_read_b = 1'b1;
    step(1);
    step(1);
    chk("ra_mem_read_acc2", mem_read_b, 1);
    rst_n_b = 1'b0;
    step(1);
    chk("ra_mem_read_rst", mem_read_b, 0);
    chk("ra_d_ready_rst", d_ready_b, 0);
    rst_n_b = 1'b1;
    wait_d_b("ra_reissue_latency", 4);
    chk("ra_d_rdata", d_rdata_b, 32'h33334444);
    d_read_b = 1'b0;
    step(1);

    // read and write together: store wins, proto_err pulses once
    d_addr_b = 32'h44; d_wdata_b = 32'h12345678; d_read_b = 1'b1; d_write_b = 1'b1;
    step(1);
    chk("pe_proto_err", proto_err_b, 1);
    chk("pe_mem_write", mem_write_b, 1);
    chk("pe_mem_read", mem_read_b, 0);
    step(1);
    chk("pe_proto_err_off", proto_err_b, 0);
    wait_d_b("pe_latency", 2);
    d_read_b = 1'b0; d_write_b = 1'b0;
    step(1);
    d_read_b = 1'b1;
    wait_d_b("pe_rb_latency", 4);
    chk("pe_rb_d_rdata", d_rdata_b, 32'h12345678);
    d_read_b = 1'b0;
    step(1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares one memory port between the processor's instruction-fetch requester and its load/store requester.
- Sits between Processor and Memory and drives Memory's address, data, read and write inputs.
- Sequences each access over a configurable memory latency.
- Returns per-requester ready pulses and a processor stall.

Parameters:
ADDR_W, 32, address width
DATA_W, 32, data width
MEM_LATENCY, 1, cycles mem_read/mem_write are held per access (>=1)
STARVE_LIMIT, 4, consecutive conflict losses tolerated by fetch before it is forced to win (>=1)

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  reset, synchronous, active-low
if_req  in  1  fetch request; held until if_ready
if_addr  in  ADDR_W  fetch address
if_ready  out  1  one-cycle pulse: fetch done, if_rdata valid
if_rdata  out  DATA_W  fetched instruction (registered)
d_read  in  1  load request; held until d_ready
d_write  in  1  store request; held until d_ready
d_addr  in  ADDR_W  data address
d_wdata  in  DATA_W  store data
d_ready  out  1  one-cycle pulse: load/store done
d_rdata  out  DATA_W  load data (registered)
mem_addr  out  ADDR_W  to Memory address input
mem_wdata  out  DATA_W  to Memory data_in
mem_read  out  1  to Memory mem_read
mem_write  out  1  to Memory mem_write
mem_rdata  in  DATA_W  from Memory read data
stall  out  1  (if_req & ~if_ready) | ((d_read|d_write) & ~d_ready), combinational
proto_err  out  1  one-cycle pulse when d_read and d_write are both seen at grant

Behaviour:
- Reset: clk/rst_n only; synchronous, active-low. On the first rising edge with rst_n low, the block forces:
  - state IDLE, starve_cnt 0
  - all registered outputs 0: mem_addr, mem_wdata, mem_read, mem_write, if_ready, d_ready, if_rdata, d_rdata, proto_err
- State machine IDLE -> ACCESS -> RESP -> IDLE. A transaction takes MEM_LATENCY+2 cycles.
- IDLE arbitration:
  - If only one side is pending, that side is granted.
  - If both are pending, data wins unless starve_cnt == STARVE_LIMIT, in which case fetch wins.
  - On grant, the block latches the address, wdata and operation into mem_* registers, then enters ACCESS with wait count MEM_LATENCY-1.
  - No request pending: stay in IDLE with mem_read/mem_write 0 and mem_addr/mem_wdata holding their last values.
- starve_cnt:
  - +1 when data wins a conflict. It saturates at STARVE_LIMIT.
  - Cleared to 0 on every fetch grant.
  - Unchanged on an unconflicted data grant.
  - Width is clog2(STARVE_LIMIT+1).
- ACCESS:
  - mem_read (fetch or load) or mem_write (store) is held high with a stable mem_addr/mem_wdata for exactly MEM_LATENCY cycles.
  - On the last ACCESS edge, mem_rdata is captured into if_rdata or d_rdata; reads only, because stores leave d_rdata unchanged.
  - The counter then moves to RESP.
- RESP:
  - mem strobes are 0.
  - The granted side's ready is high for this cycle only.
  - The granted requester's req seen in this cycle is ignored, because its transaction is complete.
  - The next state is always IDLE.
- Simultaneous d_read & d_write at grant: the store is performed and proto_err pulses in the first ACCESS cycle.
- A request that changes address while ungranted: the value sampled at the grant edge is used.
- Reset mid-ACCESS/RESP:
  - The block aborts immediately and no ready pulse is issued.
  - A partially applied store is accepted.
  - The requester must re-issue.
- Address/data widths pass through unchanged; there is no arithmetic besides the counters.

Decomposition:
- Package mem_arb_pkg:
  - state enum {ST_IDLE, ST_ACCESS, ST_RESP}
  - grant enum {GNT_IF, GNT_D}
  - op enum {OP_RD, OP_WR}
  - default ADDR_W/DATA_W constants
- Sub-module mem_arb_select: combinational priority pick plus the starve_cnt register. Its outputs are the grant and the next starve_cnt.
- The top level holds the FSM, latency counter and output registers.

Test Plan:
1. rst_n low for 2 cycles with all requests high -> after the 2nd edge all outputs 0; no mem strobe until rst_n is high.
2. MEM_LATENCY=1, if_req with if_addr=0x10, Memory word=0x8C010004 -> cycle 1: mem_read=1 and mem_addr=0x10; cycle 2: if_ready=1 and if_rdata=0x8C010004; cycle 3: IDLE.
3. if_req(0x20) and d_read(0x80) asserted together -> d_ready at cycle 2; fetch granted at cycle 3; if_ready at cycle 5; starve_cnt 1 then 0.
4. STARVE_LIMIT=4, both requesters continuously pending -> grant order D,D,D,D,IF,D…; fetch served within 5 transactions.
5. d_write addr 0x40 with wdata 0xDEADBEEF, MEM_LATENCY=3 -> mem_write high for exactly 3 cycles, d_ready 1 cycle later; a following d_read 0x40 returns d_rdata=0xDEADBEEF.
6. MEM_LATENCY=3, d_read in flight, rst_n low during the 2nd ACCESS cycle -> next cycle mem_read=0 and no d_ready; after release, the re-issued d_read completes normally. Also check: d_read & d_write together -> store performed and proto_err pulses once.
